// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, the NOP bubble word and
// the base-ISA opcodes the controller decodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ADDI x0, x0, 0: what the controller sees whenever no instruction is held.
    localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OP_I};

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time
// and holds the returned instruction for the controller until it is consumed.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;
    logic            req_valid_q, req_valid_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] redirect_tgt_s;

    assign redirect_tgt_s = {redirect_pc[XLEN-1:2], 2'b00};

    // Next-state and datapath update for the request/wait/hold sequence.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        case (state_q)
            S_REQ: begin
                if (req_valid_q && imem_req_ready) begin
                    // A same-cycle redirect still lets the old address go out; its data is killed.
                    state_d = S_WAIT;
                    if (redirect_en) begin
                        fetch_pc_d = redirect_tgt_s;
                        kill_d     = 1'b1;
                    end else begin
                        kill_d     = 1'b0;
                    end
                end else if (redirect_en) begin
                    fetch_pc_d = redirect_tgt_s;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_en) begin
                        fetch_pc_d = redirect_tgt_s;
                        kill_d     = 1'b0;
                        state_d    = S_REQ;
                    end else if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d       = imem_rsp_data;
                        pc_d          = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect_en) begin
                    fetch_pc_d = redirect_tgt_s;
                    kill_d     = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    fetch_pc_d    = redirect_en ? redirect_tgt_s : (pc_q + PC_STEP);
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        req_valid_d = (state_d == S_REQ);
        pc_plus4_d  = pc_d + PC_STEP;
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            kill_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + PC_STEP;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            kill_q        <= kill_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_q;
    assign opcode         = instr_q[6:0];
    assign func3          = instr_q[14:12];
    assign func7          = instr_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory with
// programmable response latency, plus a second instance started near the top of memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_stall;
    logic        w_redirect_en;
    logic [31:0] w_redirect_pc;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [6:0]  w_opcode;
    logic [2:0]  w_func3;
    logic [6:0]  w_func7;

    int          total;
    int          bad;
    int          lat;
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] log_q [0:31];
    int          n_issued;
    logic [31:0] w_log [0:7];
    int          w_n;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .opcode(opcode), .func3(func3), .func7(func7)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .stall(w_stall),
        .redirect_en(w_redirect_en), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr(w_instr), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .opcode(w_opcode), .func3(w_func3), .func7(w_func7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'h00A0_0093 : (a + 32'h1000_0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the memory model updates its outputs 1 time unit after the edge.
    task automatic tick();
        bit          acc;
        bit          delivered;
        bit          w_acc;
        logic [31:0] a;
        logic [31:0] wa;
        acc       = imem_req_valid & imem_req_ready;
        a         = imem_addr;
        delivered = imem_rsp_valid;
        w_acc     = w_req_valid & w_req_ready;
        wa        = w_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0;
            w_n  = 0;
        end else begin
            if (delivered) pend = 1'b0;
            else if (pend) cnt--;
            if (acc) begin
                pend  = 1'b1;
                cnt   = lat - 1;
                paddr = a;
                if (n_issued < 32) log_q[n_issued] = a;
                n_issued++;
            end
            if (w_acc) begin
                if (w_n < 8) w_log[w_n] = wa;
                w_n++;
            end
        end
        imem_rsp_valid = pend && (cnt == 0);
        imem_rsp_data  = pend ? mem_word(paddr) : 32'hDEAD_BEEF;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_before;
        total = 0; bad = 0; n_issued = 0; w_n = 0;
        pend = 1'b0; cnt = 0; paddr = 32'd0; lat = 1;
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        w_req_ready = 1'b1; w_rsp_valid = 1'b1; w_rsp_data = 32'h0000_0013;
        w_stall = 1'b0; w_redirect_en = 1'b0; w_redirect_pc = 32'd0;
        repeat (3) tick();

        // Reset state
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_pc_plus4", pc_plus4, 32'h0000_0004);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_opcode", {25'd0, opcode}, 32'h0000_0013);

        // Sequential fetch, zero-wait memory
        rst = 1'b0;
        wait_valid(10, n);
        check("first_latency", n, 3);
        check("seq0_pc", pc, 32'h0000_0000);
        check("seq0_instr", instr, 32'h1000_0000);
        check("seq0_pc_plus4", pc_plus4, 32'h0000_0004);
        tick();
        check("consume_valid", {31'd0, instr_valid}, 32'd0);
        check("consume_nop", instr, 32'h0000_0013);
        wait_valid(10, n);
        check("seq1_pc", pc, 32'h0000_0004);
        check("seq1_pc_plus4", pc_plus4, 32'h0000_0008);
        check("throughput", n, 2);
        tick();
        wait_valid(10, n);
        check("seq2_pc", pc, 32'h0000_0008);
        check("seq2_pc_plus4", pc_plus4, 32'h0000_000C);
        check("log0", log_q[0], 32'h0000_0000);
        check("log1", log_q[1], 32'h0000_0004);
        check("log2", log_q[2], 32'h0000_0008);

        // Stall holds an ADDI at 0x10
        tick();
        wait_valid(10, n);
        check("seq3_pc", pc, 32'h0000_000C);
        tick();
        stall = 1'b1;
        wait_valid(10, n);
        repeat (5) tick();
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_instr", instr, 32'h00A0_0093);
        check("stall_opcode", {25'd0, opcode}, 32'h0000_0013);
        check("stall_func3", {29'd0, func3}, 32'd0);
        check("stall_func7", {25'd0, func7}, 32'd0);
        check("stall_pc", pc, 32'h0000_0010);
        check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("stall_issued", n_issued, 5);

        // Redirect from HOLD, ignored while stalled, target aligned
        redirect_en = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        check("redir_stalled_pc", pc, 32'h0000_0010);
        check("redir_stalled_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0;
        tick();
        redirect_en = 1'b0;
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        wait_valid(10, n);
        check("redir_log", log_q[5], 32'h0000_0100);
        check("redir_pc", pc, 32'h0000_0100);

        // Redirect while waiting for 0x20: stale response dropped
        redirect_en = 1'b1; redirect_pc = 32'h0000_0020; lat = 4;
        tick();
        redirect_en = 1'b0;
        check("kill_addr20", imem_addr, 32'h0000_0020);
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_en = 1'b0;
        check("kill_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
        tick();
        tick();
        check("kill_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
        check("kill_valid_a", {31'd0, instr_valid}, 32'd0);
        tick();
        check("kill_valid_b", {31'd0, instr_valid}, 32'd0);
        check("kill_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("kill_next_addr", imem_addr, 32'h0000_0200);
        lat = 1;
        wait_valid(10, n);
        check("kill_log20", log_q[6], 32'h0000_0020);
        check("kill_log200", log_q[7], 32'h0000_0200);
        check("kill_pc", pc, 32'h0000_0200);
        check("kill_instr", instr, 32'h1000_0200);

        // Reset while waiting
        lat = 3;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_instr", instr, 32'h0000_0013);
        check("midrst_pc", pc, 32'h0000_0000);
        check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b0; lat = 1;
        n_before = n_issued;
        wait_valid(10, n);
        check("midrst_latency", n, 3);
        check("midrst_pc_after", pc, 32'h0000_0000);
        check("midrst_issued", n_issued, n_before + 1);
        check("midrst_first_addr", log_q[n_issued - 1], 32'h0000_0000);

        // RESET_PC at the top of memory: pc+4 wraps to 0
        check("wrap_valid", {31'd0, w_instr_valid}, 32'd1);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", w_pc_plus4, 32'h0000_0000);
        repeat (3) tick();
        check("wrap_count", w_n, 2);
        check("wrap_first", w_log[0], 32'hFFFF_FFFC);
        check("wrap_second", w_log[1], 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
